mul_err_sweep_ctrl: RTL and testbench

- Sequencer for exhaustive error characterisation of one W x W approximate multiplier netlist instance.
- The multiplier under test is a combinational (optionally externally pipelined) block with 2W operand inputs and a 2W-bit product.
- This controller drives every operand pair once and compares each returned product against an internally computed exact product.
- It accumulates error count, maximum absolute error and sum of absolute errors, then reports them with a start/busy/done handshake.

---
 rtl/mul_err_sweep_ctrl.sv | 152 +++++++++++++++
 tb/tb_mul_err_sweep_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_err_sweep_ctrl.sv
// Exhaustive error sweep sequencer for one W x W approximate multiplier instance.
// Drives every operand pair, compares the returned product and accumulates error stats.
module mul_err_sweep_ctrl #(
  parameter int unsigned W   = 6,
  parameter int unsigned LAT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [W-1:0]     op_a,
  output logic [W-1:0]     op_b,
  input  logic [2*W-1:0]   app_p,
  output logic             busy,
  output logic             done,
  output logic             res_valid,
  output logic [2*W:0]     err_count,
  output logic [2*W-1:0]   max_err,
  output logic [4*W-1:0]   sum_err
);

  localparam int unsigned PW = 2 * W;
  localparam logic [PW-1:0] VecLast = '1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   vec_q;
  logic            cmp_busy_q;
  logic            res_valid_q;
  logic [PW:0]     err_count_q;
  logic [PW-1:0]   max_err_q;
  logic [2*PW-1:0] sum_err_q;

  logic            run_v;
  logic            flush;
  logic [PW-1:0]   prod;
  logic [PW-1:0]   exact;
  logic            cmp_v;
  logic            dl_busy;
  logic [PW-1:0]   err;

  assign op_a  = vec_q[PW-1:W];
  assign op_b  = vec_q[W-1:0];
  assign run_v = (state_q == StRun);
  assign flush = abort && ((state_q == StRun) || (state_q == StDrain));
  assign prod  = PW'(op_a) * PW'(op_b);

  // Exact product travels alongside the multiplier latency so each compare sees its own vector.
  if (LAT == 0) begin : g_no_dl
    assign exact   = prod;
    assign cmp_v   = run_v;
    assign dl_busy = 1'b0;
  end else begin : g_dl
    logic [PW-1:0]  dl_p_q [LAT];
    logic [LAT-1:0] dl_v_q;

    always_ff @(posedge clk) begin
      if (rst || flush) begin
        dl_v_q <= '0;
        for (int i = 0; i < LAT; i++) dl_p_q[i] <= '0;
      end else begin
        dl_p_q[0] <= prod;
        dl_v_q[0] <= run_v;
        for (int i = 1; i < LAT; i++) begin
          dl_p_q[i] <= dl_p_q[i-1];
          dl_v_q[i] <= dl_v_q[i-1];
        end
      end
    end

    assign exact   = dl_p_q[LAT-1];
    assign cmp_v   = dl_v_q[LAT-1];
    assign dl_busy = |dl_v_q;
  end

  assign err = (exact >= app_p) ? (exact - app_p) : (app_p - exact);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StRun;
      end
      StRun: begin
        if (abort) begin
          state_d = StIdle;
        end else if (vec_q == VecLast) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (abort) begin
          state_d = StIdle;
        end else if (!dl_busy && !cmp_v && !cmp_busy_q) begin
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q == StRun) || (state_q == StDrain);
    done = (state_q == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec_q       <= '0;
      cmp_busy_q  <= 1'b0;
      res_valid_q <= 1'b0;
      err_count_q <= '0;
      max_err_q   <= '0;
      sum_err_q   <= '0;
    end else begin
      cmp_busy_q <= cmp_v && !flush;
      if ((state_q == StIdle) && start) begin
        vec_q       <= '0;
        res_valid_q <= 1'b0;
        err_count_q <= '0;
        max_err_q   <= '0;
        sum_err_q   <= '0;
      end
      // The operand register doubles as the vector counter; it parks at zero outside RUN.
      if (state_q == StRun) begin
        vec_q <= (flush || (vec_q == VecLast)) ? '0 : vec_q + PW'(1);
      end
      if (cmp_v && !flush) begin
        if (err != '0) err_count_q <= err_count_q + (PW + 1)'(1);
        if (err > max_err_q) max_err_q <= err;
        sum_err_q <= sum_err_q + (2 * PW)'(err);
      end
      if (state_d == StDone) res_valid_q <= 1'b1;
    end
  end

  assign res_valid = res_valid_q;
  assign err_count = err_count_q;
  assign max_err   = max_err_q;
  assign sum_err   = sum_err_q;

endmodule

// File: tb/tb_mul_err_sweep_ctrl.sv
// Scoreboard bench: two controllers (LAT=0 and LAT=2) swept side by side with shared controls.
module tb_mul_err_sweep_ctrl;

  localparam int unsigned W  = 6;
  localparam int unsigned PW = 2 * W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, abort;
  int   mode0;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0]    op_a0, op_b0, op_a2, op_b2;
  logic [PW-1:0]   app_p0, app_p2, me0, me2;
  logic            busy0, done0, rv0, busy2, done2, rv2;
  logic [PW:0]     ec0, ec2;
  logic [2*PW-1:0] se0, se2;
  logic [PW-1:0]   d1, d2;

  // LAT=0 multiplier model: exact (mode 0) or stuck at zero (mode 1).
  assign app_p0 = (mode0 == 0) ? PW'(op_a0) * PW'(op_b0) : '0;
  // LAT=2 multiplier model: two-stage pipelined product with bit 0 flipped.
  always @(posedge clk) begin
    d1 <= PW'(op_a2) * PW'(op_b2);
    d2 <= d1;
  end
  assign app_p2 = d2 ^ PW'(1);

  mul_err_sweep_ctrl #(.W(W), .LAT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .op_a(op_a0), .op_b(op_b0),
    .app_p(app_p0), .busy(busy0), .done(done0), .res_valid(rv0), .err_count(ec0),
    .max_err(me0), .sum_err(se0)
  );

  mul_err_sweep_ctrl #(.W(W), .LAT(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .op_a(op_a2), .op_b(op_b2),
    .app_p(app_p2), .busy(busy2), .done(done2), .res_valid(rv2), .err_count(ec2),
    .max_err(me2), .sum_err(se2)
  );

  typedef struct {
    int ec;
    int me;
    int se;
    int rel;
  } exp_t;

  exp_t q0[$];
  exp_t q2[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input int mode, input int lat);
    exp_t r;
    int ex, ap, e;
    r.ec = 0; r.me = 0; r.se = 0;
    for (int a = 0; a < 64; a++) begin
      for (int b = 0; b < 64; b++) begin
        ex = a * b;
        ap = (mode == 0) ? ex : (mode == 1) ? 0 : (ex ^ 1);
        e  = (ex > ap) ? ex - ap : ap - ex;
        if (e != 0) r.ec++;
        if (e > r.me) r.me = e;
        r.se += e;
      end
    end
    r.rel = 4096 + lat + 2;
    return r;
  endfunction

  task automatic check_zero(input string tag);
    check_val({tag, "_op0"}, {op_a0, op_b0}, 0);
    check_val({tag, "_op2"}, {op_a2, op_b2}, 0);
    check_val({tag, "_ctl0"}, {busy0, done0, rv0}, 0);
    check_val({tag, "_ctl2"}, {busy2, done2, rv2}, 0);
    check_val({tag, "_ec0"}, ec0, 0);
    check_val({tag, "_me0"}, me0, 0);
    check_val({tag, "_se0"}, se0, 0);
    check_val({tag, "_ec2"}, ec2, 0);
    check_val({tag, "_se2"}, se2, 0);
  endtask

  task automatic check_done(input int which, input int k);
    exp_t e;
    if (which == 0) begin
      check_val("sb0_nonempty", q0.size() > 0, 1);
      if (q0.size() == 0) return;
      e = q0.pop_front();
      check_val("ec0", ec0, e.ec);
      check_val("me0", me0, e.me);
      check_val("se0", se0, e.se);
      check_val("done_edge0", k, e.rel);
      check_val("rv_busy0", {rv0, busy0}, 2'b10);
    end else begin
      check_val("sb2_nonempty", q2.size() > 0, 1);
      if (q2.size() == 0) return;
      e = q2.pop_front();
      check_val("ec2", ec2, e.ec);
      check_val("me2", me2, e.me);
      check_val("se2", se2, e.se);
      check_val("done_edge2", k, e.rel);
      check_val("rv_busy2", {rv2, busy2}, 2'b10);
    end
  endtask

  // k = edges since the edge that sampled start; vector k is on the operands in cycle k.
  task automatic run_sweep(input int mode, input bit pulses, input int abort_at, input int rst_at,
                           input bit start_in_done);
    int s, k;
    bit seen0, seen2, stray;
    mode0 = mode;
    if (abort_at < 0 && rst_at < 0) begin
      q0.push_back(model(mode, 0));
      q2.push_back(model(2, 2));
    end
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    s = cyc;
    k = 0;
    seen0 = 1'b0;
    seen2 = 1'b0;
    while (!(seen0 && seen2) && k < 4300) begin
      k = cyc - s;
      start = 1'b0;
      if (k == 0 || k == 1 || k == 70 || k == 4095) begin
        check_val("op0_vec", {op_a0, op_b0}, k);
        check_val("op2_vec", {op_a2, op_b2}, k);
      end
      if (pulses && (k == 5 || k == 1234 || k == 4095 || k == 4097)) start = 1'b1;
      if (k == abort_at) begin
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        check_val("abort_busy", {busy0, busy2}, 0);
        check_val("abort_ops", {op_a0, op_b0, op_a2, op_b2}, 0);
        check_val("abort_rv", {rv0, rv2}, 0);
        stray = 1'b0;
        for (int j = 0; j < 20; j++) begin
          @(negedge clk);
          stray |= done0 | done2 | busy0 | busy2;
        end
        check_val("abort_no_done", stray, 0);
        return;
      end
      if (k == rst_at) begin
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        check_zero("midrst");
        return;
      end
      if (done0) begin
        if (seen0) check_val("done0_extra", 1, 0);
        else begin
          seen0 = 1'b1;
          check_done(0, k);
          if (start_in_done) start = 1'b1;
        end
      end
      if (done2) begin
        if (seen2) check_val("done2_extra", 1, 0);
        else begin
          seen2 = 1'b1;
          check_done(2, k);
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    check_val("done0_seen", seen0, 1);
    check_val("done2_seen", seen2, 1);
    check_val("post_idle0", {busy0, done0, rv0}, 3'b001);
    @(negedge clk);
    check_val("post_idle2", {busy2, done2, rv2}, 3'b001);
    check_val("post_idle0b", {busy0, rv0}, 2'b01);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    mode0 = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_zero("reset");
    // abort while idle must do nothing
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    check_val("idle_abort", {busy0, busy2}, 0);

    run_sweep(0, 1'b0, -1, -1, 1'b0);
    run_sweep(1, 1'b0, -1, -1, 1'b0);
    run_sweep(0, 1'b1, -1, -1, 1'b1);
    run_sweep(1, 1'b0, 1000, -1, 1'b0);
    run_sweep(1, 1'b0, -1, -1, 1'b0);
    run_sweep(1, 1'b0, -1, 2000, 1'b0);
    run_sweep(1, 1'b0, -1, -1, 1'b0);

    check_val("sb0_drained", q0.size(), 0);
    check_val("sb2_drained", q2.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
